// File: rtl/udma_i2s_pkg.sv
// Shared types and helpers for the I2S slave-side transmitter.
package udma_i2s_pkg;

    localparam int I2S_BITS_W = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ALIGN  = 2'd1,
        ACTIVE = 2'd2
    } i2s_stx_state_e;

    function automatic logic [I2S_BITS_W-1:0] cnt_sat_inc(input logic [I2S_BITS_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/udma_i2s_slave_tx_if.sv
// Valid/ready word stream feeding the I2S slave transmitter.
interface udma_i2s_slave_tx_if #(
    parameter int DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/i2s_pad_sync_edge.sv
// N-stage pad synchronizer with single-cycle rise/fall strobes on the synced level.
module i2s_pad_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pad_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;
endmodule

// File: rtl/udma_i2s_slave_tx.sv
// I2S slave transmitter: follows external SCK/WS and shifts stream words onto SD
// with standard I2S one-bit delay framing.
module udma_i2s_slave_tx
    import udma_i2s_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cfg_en_i,
    input  logic                  cfg_2ch_i,
    input  logic                  cfg_lsb_first_i,
    input  logic [I2S_BITS_W-1:0] cfg_bits_word_i,
    input  logic                  pad_sck_i,
    input  logic                  pad_ws_i,
    output logic                  pad_sd_o,
    udma_i2s_slave_tx_if.slave    strm,
    output logic                  underrun_o,
    output logic                  busy_o
);
    logic sck_rise, sck_fall, sck_lvl_unused;
    logic ws_sync, ws_rise_unused, ws_fall_unused;

    i2s_pad_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pad_i  (pad_sck_i),
        .sync_o (sck_lvl_unused),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    i2s_pad_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ws_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .pad_i  (pad_ws_i),
        .sync_o (ws_sync),
        .rise_o (ws_rise_unused),
        .fall_o (ws_fall_unused)
    );

    i2s_stx_state_e        state_q;
    logic                  ws_s_q, ws_s_d;
    logic [DATA_WIDTH-1:0] shreg_q;
    logic [I2S_BITS_W-1:0] cnt_q;
    logic                  sd_q, ready_q, underrun_q, busy_q;

    logic slot_start, need_data, do_load;

    // Counter beyond the word width, or MSB-first index wrap, yields trailing zeros.
    function automatic logic slot_bit(input logic [DATA_WIDTH-1:0] sh,
                                      input logic [I2S_BITS_W-1:0] cnt,
                                      input logic [I2S_BITS_W-1:0] bits,
                                      input logic                  lsb);
        logic [I2S_BITS_W-1:0] idx;
        idx = lsb ? cnt : bits - cnt;
        if (cnt > bits) return 1'b0;
        return sh[idx];
    endfunction

    assign ws_s_d     = sck_rise ? ws_sync : ws_s_q;
    assign slot_start = sck_rise & (ws_sync != ws_s_q);
    assign need_data  = ~ws_sync | cfg_2ch_i;
    // The aligning left-slot start also loads, so the first left word is not lost.
    assign do_load    = cfg_en_i & slot_start &
                        ((state_q == ACTIVE) | ((state_q == ALIGN) & ~ws_sync));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            ws_s_q     <= 1'b0;
            shreg_q    <= '0;
            cnt_q      <= '0;
            sd_q       <= 1'b0;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
            ws_s_q     <= ws_s_d;
            if (!cfg_en_i) begin
                state_q <= IDLE;
                sd_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q <= ALIGN;
                        sd_q    <= 1'b0;
                    end
                    ALIGN: begin
                        sd_q <= 1'b0;
                        if (do_load) begin
                            state_q <= ACTIVE;
                            busy_q  <= 1'b1;
                        end
                    end
                    ACTIVE: begin
                        if (!slot_start && sck_fall) begin
                            sd_q  <= slot_bit(shreg_q, cnt_q, cfg_bits_word_i, cfg_lsb_first_i);
                            cnt_q <= cnt_sat_inc(cnt_q);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
                if (do_load) begin
                    cnt_q <= '0;
                    if (need_data && strm.valid) begin
                        shreg_q <= strm.data;
                        ready_q <= 1'b1;
                    end else begin
                        shreg_q    <= '0;
                        underrun_q <= need_data;
                    end
                end
            end
        end
    end

    assign pad_sd_o   = sd_q;
    assign strm.ready = ready_q;
    assign underrun_o = underrun_q;
    assign busy_o     = busy_q;
endmodule

// File: tb/tb_udma_i2s_slave_tx.sv
// Bench for udma_i2s_slave_tx: table of framing cases plus reset/enable corner sequences.
module tb_udma_i2s_slave_tx;
    localparam int HALF = 4;
    localparam int NV   = 8;

    logic       clk, rst, cfg_en, cfg_2ch, cfg_lsb;
    logic [4:0] cfg_bits;
    logic       pad_sck, pad_ws, pad_sd, underrun, busy;

    udma_i2s_slave_tx_if #(.DATA_WIDTH(32)) sif ();

    udma_i2s_slave_tx #(.SYNC_STAGES(2), .DATA_WIDTH(32)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .cfg_en_i        (cfg_en),
        .cfg_2ch_i       (cfg_2ch),
        .cfg_lsb_first_i (cfg_lsb),
        .cfg_bits_word_i (cfg_bits),
        .pad_sck_i       (pad_sck),
        .pad_ws_i        (pad_ws),
        .pad_sd_o        (pad_sd),
        .strm            (sif),
        .underrun_o      (underrun),
        .busy_o          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        two_ch;
        logic        lsb;
        logic [4:0]  bits;
        int          slot_len;
        logic [31:0] w_l;
        logic [31:0] w_r;
        logic        have_l;
        logic        have_r;
        int          exp_pops;
        int          exp_unds;
    } vec_t;

    vec_t        vecs[NV];
    logic [31:0] got_l[NV];
    logic [31:0] q[$];
    bit          samp[$];
    int          errors, checks;
    int          pop_cnt, und_cnt, zero_viol;
    bit          zero_mon;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_src();
        sif.valid = (q.size() > 0);
        sif.data  = (q.size() > 0) ? q[0] : 32'h0;
    endtask

    task automatic push(input logic [31:0] w);
        q.push_back(w);
        drive_src();
    endtask

    // One clk cycle: stream source pops on ready, monitors accumulate.
    task automatic tick();
        @(negedge clk);
        if (sif.ready) begin
            pop_cnt++;
            if (q.size() > 0) void'(q.pop_front());
        end
        if (underrun) und_cnt++;
        if (zero_mon && pad_sd) zero_viol++;
        drive_src();
    endtask

    // One SCK period, WS changing with the fall; SD sampled just before the rise.
    task automatic sck_bit(input logic ws);
        pad_sck = 1'b0;
        pad_ws  = ws;
        repeat (HALF) tick();
        samp.push_back(pad_sd);
        pad_sck = 1'b1;
        repeat (HALF) tick();
    endtask

    // Serial order the receiver should see for one slot.
    function automatic logic [31:0] exp_stream(input logic [31:0] w, input logic [4:0] bits,
                                               input logic lsb, input int slot_len);
        logic [31:0] s;
        int n;
        s = '0;
        n = int'(bits) + 1;
        for (int j = 0; j < slot_len; j++)
            if (j < n) s[j] = lsb ? w[j] : w[n-1-j];
        return s;
    endfunction

    // Receiver latches slot bit j on rise j+1 after the WS edge.
    function automatic logic [31:0] got_stream(input int start, input int slot_len);
        logic [31:0] s;
        s = '0;
        for (int j = 0; j < slot_len; j++) s[j] = samp[start+j+1];
        return s;
    endfunction

    task automatic run_vec(input vec_t v, input int idx, output logic [31:0] gl);
        int p0, u0, ls, rs;
        logic [31:0] el, er;
        cfg_en   = 1'b0;
        cfg_2ch  = v.two_ch;
        cfg_lsb  = v.lsb;
        cfg_bits = v.bits;
        tick();
        cfg_en = 1'b1;
        tick(); tick();
        p0 = pop_cnt;
        u0 = und_cnt;
        if (v.have_l) push(v.w_l);
        if (v.have_l && v.two_ch && v.have_r) push(v.w_r);
        sck_bit(1'b1); sck_bit(1'b1);
        ls = samp.size();
        for (int k = 0; k < v.slot_len; k++) begin
            if (k == 2 && !v.have_l && v.have_r && v.two_ch) push(v.w_r);
            sck_bit(1'b0);
        end
        rs = samp.size();
        for (int k = 0; k < v.slot_len; k++) begin
            sck_bit(1'b1);
            if (k == 0) check($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
        end
        sck_bit(1'b1); sck_bit(1'b1);
        cfg_en = 1'b0;
        tick();
        q.delete();
        drive_src();
        el = v.have_l ? v.w_l : 32'h0;
        er = (v.two_ch && v.have_r) ? v.w_r : 32'h0;
        gl = got_stream(ls, v.slot_len);
        check($sformatf("v%0d_left", idx), gl, exp_stream(el, v.bits, v.lsb, v.slot_len));
        check($sformatf("v%0d_right", idx), got_stream(rs, v.slot_len),
              exp_stream(er, v.bits, v.lsb, v.slot_len));
        check($sformatf("v%0d_pops", idx), 32'(pop_cnt - p0), 32'(v.exp_pops));
        check($sformatf("v%0d_unds", idx), 32'(und_cnt - u0), 32'(v.exp_unds));
    endtask

    initial begin
        int p0, u0, ls;
        logic [31:0] rx;
        errors = 0; checks = 0; pop_cnt = 0; und_cnt = 0; zero_viol = 0; zero_mon = 0;
        rst = 1'b1; cfg_en = 1'b0; cfg_2ch = 1'b1; cfg_lsb = 1'b0; cfg_bits = 5'd15;
        pad_sck = 1'b0; pad_ws = 1'b0;
        sif.data = '0; sif.valid = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 5'd15, 16, 32'h0000A5F0, 32'h00000F0F, 1'b1, 1'b1, 2, 0};
        vecs[1] = '{1'b1, 1'b1, 5'd23, 32, 32'h00800001, 32'h00123456, 1'b1, 1'b1, 2, 0};
        vecs[2] = '{1'b0, 1'b0, 5'd15, 16, 32'h00001234, 32'h0000FFFF, 1'b1, 1'b0, 1, 0};
        vecs[3] = '{1'b1, 1'b0, 5'd15, 16, 32'h0000FFFF, 32'h0000BEEF, 1'b0, 1'b1, 1, 1};
        vecs[4] = '{1'b1, 1'b0, 5'd31, 24, 32'hDEADBEEF, 32'h89ABCDEF, 1'b1, 1'b1, 2, 0};
        for (int i = 5; i < NV; i++) begin
            vecs[i].two_ch   = 1'($urandom_range(0, 1));
            vecs[i].lsb      = 1'($urandom_range(0, 1));
            vecs[i].bits     = 5'($urandom_range(7, 31));
            vecs[i].slot_len = $urandom_range(8, 32);
            vecs[i].w_l      = $urandom;
            vecs[i].w_r      = $urandom;
            vecs[i].have_l   = 1'b1;
            vecs[i].have_r   = 1'b1;
            vecs[i].exp_pops = vecs[i].two_ch ? 2 : 1;
            vecs[i].exp_unds = 0;
        end

        repeat (3) tick();
        check("rst_sd", 32'(pad_sd), 32'd0);
        check("rst_ready", 32'(sif.ready), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < NV; i++) run_vec(vecs[i], i, got_l[i]);

        rx = '0;
        for (int j = 0; j < 16; j++) rx = {rx[30:0], got_l[0][j]};
        check("rx_word_msb16", rx, 32'h0000A5F0);
        check("lsb24_pattern", got_l[1], 32'h00800001);

        // Enable mid-frame while WS=1, then drop enable mid-slot.
        cfg_en = 1'b0; cfg_2ch = 1'b1; cfg_lsb = 1'b0; cfg_bits = 5'd15;
        tick();
        zero_mon = 1; zero_viol = 0;
        p0 = pop_cnt;
        push(32'h0000FFFF); push(32'h0000FFFF);
        sck_bit(1'b1);
        cfg_en = 1'b1;
        sck_bit(1'b1); sck_bit(1'b1);
        check("align_quiet", 32'(zero_viol), 32'd0);
        check("align_busy", 32'(busy), 32'd0);
        zero_mon = 0;
        repeat (8) sck_bit(1'b0);
        check("en_active_sd", 32'(pad_sd), 32'd1);
        check("en_active_busy", 32'(busy), 32'd1);
        cfg_en = 1'b0;
        tick();
        check("dis_sd_next", 32'(pad_sd), 32'd0);
        check("dis_busy_next", 32'(busy), 32'd0);
        zero_mon = 1; zero_viol = 0;
        repeat (8) sck_bit(1'b0);
        repeat (4) sck_bit(1'b1);
        check("dis_quiet", 32'(zero_viol), 32'd0);
        check("dis_pops", 32'(pop_cnt - p0), 32'd1);
        zero_mon = 0;
        q.delete(); drive_src();

        // Reset pulse mid-ACTIVE, then re-align on the next WS 1->0.
        cfg_en = 1'b1;
        tick(); tick();
        push(32'h0000FFFF); push(32'h0000FFFF);
        sck_bit(1'b1); sck_bit(1'b1);
        repeat (6) sck_bit(1'b0);
        check("pre_rst_sd", 32'(pad_sd), 32'd1);
        rst = 1'b1;
        tick();
        check("rst_mid_sd", 32'(pad_sd), 32'd0);
        check("rst_mid_ready", 32'(sif.ready), 32'd0);
        check("rst_mid_underrun", 32'(underrun), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        q.delete(); drive_src();
        p0 = pop_cnt; u0 = und_cnt;
        zero_mon = 1; zero_viol = 0;
        repeat (10) sck_bit(1'b0);
        repeat (16) sck_bit(1'b1);
        check("realign_quiet", 32'(zero_viol), 32'd0);
        check("realign_busy_low", 32'(busy), 32'd0);
        zero_mon = 0;
        push(32'h00005A5A);
        ls = samp.size();
        repeat (16) sck_bit(1'b0);
        check("realign_busy", 32'(busy), 32'd1);
        sck_bit(1'b1); sck_bit(1'b1);
        check("realign_left", got_stream(ls, 16), exp_stream(32'h00005A5A, 5'd15, 1'b0, 16));
        check("realign_pops", 32'(pop_cnt - p0), 32'd1);
        check("realign_underrun", 32'(und_cnt - u0), 32'd1);
        cfg_en = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
